// File: rtl/fir_err_accum_if.sv
// Sample/result bundle between the approximate FIR output stage and the error accumulator.
// The master drives the sample pairs and start; the slave returns status and latched metrics.
interface fir_err_accum_if #(
    parameter int WIDTH    = 16,
    parameter int WIN_LOG2 = 10
);
    logic                          start;
    logic                          in_valid;
    logic signed [WIDTH-1:0]       y_apx;
    logic signed [WIDTH-1:0]       y_ref;
    logic                          busy;
    logic                          done;
    logic [WIDTH+WIN_LOG2-1:0]     sum_ed;
    logic [WIDTH-1:0]              max_ed;
    logic [WIN_LOG2:0]             err_cnt;
    logic [2*WIDTH+WIN_LOG2-1:0]   sse;

    modport master (
        output start, in_valid, y_apx, y_ref,
        input  busy, done, sum_ed, max_ed, err_cnt, sse
    );

    modport slave (
        input  start, in_valid, y_apx, y_ref,
        output busy, done, sum_ed, max_ed, err_cnt, sse
    );
endinterface

// File: rtl/fir_err_accum.sv
// Windowed error metrics (sum/max/count of |y_apx - y_ref|) for approximate-filter characterisation.
// Define ERR_SQ_EN to add the sum-of-squared-error accumulator; otherwise sse is tied to 0.
module fir_err_accum #(
    parameter int WIDTH    = 16,
    parameter int WIN_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rstN,
    fir_err_accum_if.slave   bus
);
    localparam int SUM_W = WIDTH + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam int SSE_W = 2 * WIDTH + WIN_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [WIN_LOG2-1:0]   smp_cnt_reg;
    logic                  accept;
    logic                  last_smp;
    logic                  clear_acc;

    logic [WIDTH:0]        diff_w;
    logic [WIDTH-1:0]      ed_w;

    logic                  s1_valid_reg;
    logic [WIDTH-1:0]      s1_ed_reg;
    logic                  s1_ne_reg;

    logic [SUM_W-1:0]      sum_acc_reg, sum_next;
    logic [WIDTH-1:0]      max_acc_reg, max_next;
    logic [CNT_W-1:0]      cnt_acc_reg, cnt_next;

    logic [SUM_W-1:0]      sum_out_reg;
    logic [WIDTH-1:0]      max_out_reg;
    logic [CNT_W-1:0]      cnt_out_reg;

    assign accept   = (state_reg == RUN) && bus.in_valid;
    assign last_smp = &smp_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clear_acc  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = RUN;
                    clear_acc  = 1'b1;
                end
            end
            RUN: begin
                if (accept && last_smp) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    state_next = RUN;
                    clear_acc  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Counter wraps back to zero on the last sample, so it is ready for the next window.
    always_ff @(posedge clk) begin
        if (!rstN || clear_acc) begin
            smp_cnt_reg <= '0;
        end else if (accept) begin
            smp_cnt_reg <= smp_cnt_reg + WIN_LOG2'(1);
        end
    end

    // One extra bit makes the difference exact; its magnitude always fits back into WIDTH bits.
    assign diff_w = {bus.y_apx[WIDTH-1], bus.y_apx} - {bus.y_ref[WIDTH-1], bus.y_ref};
    assign ed_w   = diff_w[WIDTH] ? (~diff_w[WIDTH-1:0] + WIDTH'(1)) : diff_w[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_valid_reg <= 1'b0;
            s1_ed_reg    <= '0;
            s1_ne_reg    <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_ed_reg <= ed_w;
                s1_ne_reg <= |diff_w;
            end
        end
    end

    always_comb begin
        sum_next = sum_acc_reg;
        max_next = max_acc_reg;
        cnt_next = cnt_acc_reg;
        if (s1_valid_reg) begin
            sum_next = sum_acc_reg + {{WIN_LOG2{1'b0}}, s1_ed_reg};
            cnt_next = cnt_acc_reg + {{WIN_LOG2{1'b0}}, s1_ne_reg};
            if (s1_ed_reg > max_acc_reg) begin
                max_next = s1_ed_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN || clear_acc) begin
            sum_acc_reg <= '0;
            max_acc_reg <= '0;
            cnt_acc_reg <= '0;
        end else begin
            sum_acc_reg <= sum_next;
            max_acc_reg <= max_next;
            cnt_acc_reg <= cnt_next;
        end
    end

    // Results capture the accumulator including the last sample still in stage 1.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            sum_out_reg <= '0;
            max_out_reg <= '0;
            cnt_out_reg <= '0;
        end else if (state_reg == DRAIN) begin
            sum_out_reg <= sum_next;
            max_out_reg <= max_next;
            cnt_out_reg <= cnt_next;
        end
    end

`ifdef ERR_SQ_EN
    logic [2*WIDTH-1:0]    ed_ext_w;
    logic [2*WIDTH-1:0]    s1_sq_reg;
    logic [SSE_W-1:0]      sse_acc_reg, sse_next;
    logic [SSE_W-1:0]      sse_out_reg;

    assign ed_ext_w = {{WIDTH{1'b0}}, ed_w};
    assign sse_next = s1_valid_reg ? (sse_acc_reg + {{WIN_LOG2{1'b0}}, s1_sq_reg}) : sse_acc_reg;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            s1_sq_reg <= '0;
        end else if (accept) begin
            s1_sq_reg <= ed_ext_w * ed_ext_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN || clear_acc) begin
            sse_acc_reg <= '0;
        end else begin
            sse_acc_reg <= sse_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            sse_out_reg <= '0;
        end else if (state_reg == DRAIN) begin
            sse_out_reg <= sse_next;
        end
    end

    assign bus.sse = sse_out_reg;
`else
    assign bus.sse = '0;
`endif

    assign bus.busy    = (state_reg == RUN) || (state_reg == DRAIN);
    assign bus.done    = (state_reg == DONE);
    assign bus.sum_ed  = sum_out_reg;
    assign bus.max_ed  = max_out_reg;
    assign bus.err_cnt = cnt_out_reg;
endmodule

// File: tb/tb_fir_err_accum.sv
// Self-checking bench for fir_err_accum with a 4-sample window: stimulus table plus
// hand-written start-in-DONE and mid-window reset sequences, window results via a scoreboard queue.
module tb_fir_err_accum;
    localparam int WIDTH    = 16;
    localparam int WIN_LOG2 = 2;
    localparam int WIN      = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        bit st;
        bit v;
        int a;
        int r;
        int w;
    } vec_t;

    typedef struct {
        longint sum;
        longint mx;
        longint cnt;
        longint sse;
    } res_t;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    fir_err_accum_if #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) bus ();

    fir_err_accum #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    vec_t tbl[$];
    res_t exp_win[$];
    res_t sb[$];
    res_t hold;
    res_t cur_exp;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mstate   = M_IDLE;
    int   n_acc    = 0;

    int pa[4] = '{100, -5, 32767, 7};
    int pr[4] = '{90, 5, -32768, 7};

    function automatic longint sq(longint x);
`ifdef ERR_SQ_EN
        return x;
`else
        return 0;
`endif
    endfunction

    function automatic int garbage();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(bit st, bit v, int a, int r, int w);
        vec_t t;
        t.st = st; t.v = v; t.a = a; t.r = r; t.w = w;
        tbl.push_back(t);
    endtask

    // Apply one cycle of stimulus, advance the reference state, then check all outputs.
    task automatic cyc(bit st, bit v, int a, int r);
        bus.start    = st;
        bus.in_valid = v;
        bus.y_apx    = WIDTH'(a);
        bus.y_ref    = WIDTH'(r);
        @(posedge clk);
        if (!rstN) begin
            mstate = M_IDLE;
            n_acc  = 0;
            sb.delete();
            hold   = '{0, 0, 0, 0};
        end else begin
            case (mstate)
                M_IDLE:  if (st) begin mstate = M_RUN; n_acc = 0; end
                M_RUN: begin
                    if (v) begin
                        n_acc++;
                        if (n_acc == WIN) begin
                            sb.push_back(cur_exp);
                            mstate = M_DRAIN;
                        end
                    end
                end
                M_DRAIN: mstate = M_DONE;
                default: begin
                    if (st) begin mstate = M_RUN; n_acc = 0; end
                    else mstate = M_IDLE;
                end
            endcase
        end
        #1;
        check("busy", longint'(bus.busy), longint'(mstate == M_RUN || mstate == M_DRAIN));
        check("done", longint'(bus.done), longint'(mstate == M_DONE));
        if (mstate == M_DONE) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard: done reached with no pending window (t=%0t)", $time);
            end else begin
                hold = sb.pop_front();
            end
        end
        check("sum_ed", longint'(bus.sum_ed), hold.sum);
        check("max_ed", longint'(bus.max_ed), hold.mx);
        check("err_cnt", longint'(bus.err_cnt), hold.cnt);
        check("sse", longint'(bus.sse), hold.sse);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, garbage(), garbage());
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t res_zero, res_b, res_c, res_d;
        res_zero = '{0, 0, 0, 0};
        res_b    = '{65555, 65535, 3, sq(64'd4294836425)};
        res_c    = '{4, 1, 4, sq(4)};
        res_d    = '{65542, 65535, 3, sq(64'd4294836250)};
        hold     = res_zero;
        cur_exp  = res_zero;

        exp_win.push_back(res_zero);
        exp_win.push_back(res_b);
        exp_win.push_back(res_b);
        exp_win.push_back(res_b);

        // Window 0: identical samples, no error.
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < WIN; i++) add(0, 1, 1234, 1234, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0);
        // Window 1: back-to-back error pairs.
        add(1, 0, 0, 0, 1);
        for (int i = 0; i < WIN; i++) add(0, 1, pa[i], pr[i], 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1);
        // Window 2: same pairs with invalid garbage cycles between them.
        add(1, 0, 0, 0, 2);
        for (int i = 0; i < WIN; i++) begin
            add(0, 1, pa[i], pr[i], 2);
            add(0, 0, garbage(), garbage(), 2);
        end
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 2);
        // Window 3: start pulses during RUN must be ignored.
        add(1, 0, 0, 0, 3);
        add(0, 1, pa[0], pr[0], 3);
        add(1, 0, garbage(), garbage(), 3);
        add(0, 1, pa[1], pr[1], 3);
        add(1, 1, pa[2], pr[2], 3);
        add(0, 1, pa[3], pr[3], 3);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 3);

        // Reset, with start asserted while held in reset.
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.y_apx = '0; bus.y_ref = '0;
        rstN = 1'b0;
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b1, 1'b1, 5, 9);
        rstN = 1'b1;
        idle(2);

        foreach (tbl[i]) begin
            cur_exp = exp_win[tbl[i].w];
            cyc(tbl[i].st, tbl[i].v, tbl[i].a, tbl[i].r);
        end

        // Start in the DONE cycle: previous results must stay until the new done.
        cur_exp = res_b;
        cyc(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < WIN; i++) cyc(1'b0, 1'b1, pa[i], pr[i]);
        cyc(1'b0, 1'b0, 0, 0);
        cur_exp = res_c;
        cyc(1'b1, 1'b1, 999, 0);
        for (int i = 0; i < WIN; i++) cyc(1'b0, 1'b1, 1, 0);
        idle(3);

        // Reset after two accepted samples: no done, outputs cleared, clean next window.
        cur_exp = res_b;
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, 100, 90);
        cyc(1'b0, 1'b1, -5, 5);
        rstN = 1'b0;
        cyc(1'b0, 1'b1, 32767, -32768);
        rstN = 1'b1;
        idle(3);
        cur_exp = res_d;
        cyc(1'b1, 1'b0, 0, 0);
        cyc(1'b0, 1'b1, -3, 0);
        cyc(1'b0, 1'b1, 0, 0);
        cyc(1'b0, 1'b1, -32768, 32767);
        cyc(1'b0, 1'b1, 5, 1);
        idle(3);

        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
